// File: rtl/instruction_encoder_if.sv
// Field-beat handshake and instruction-memory write port of the instruction encoder.
// The master is the host sequencer and the memory; the slave is the encoder.
interface instruction_encoder_if #(
    parameter int unsigned ADDR_W = 10
);
    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic              last;
    logic [1:0]        fmt;
    logic [5:0]        opcode;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [4:0]        shamt;
    logic [5:0]        funct;
    logic [15:0]       immediate;
    logic [25:0]       address;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              done;
    logic              err;

    modport master (
        output start, in_valid, last, fmt, opcode, rs, rt, rd, shamt, funct, immediate, address,
        input  in_ready, mem_we, mem_addr, mem_wdata, count, full, done, err
    );

    modport slave (
        input  start, in_valid, last, fmt, opcode, rs, rt, rd, shamt, funct, immediate, address,
        output in_ready, mem_we, mem_addr, mem_wdata, count, full, done, err
    );
endinterface

// File: rtl/instruction_encoder.sv
// Packs decoded MIPS fields into 32-bit instruction words and writes them to
// consecutive instruction-memory addresses starting at BASE_ADDR.
module instruction_encoder #(
    parameter int unsigned MEM_DEPTH = 1024,
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    instruction_encoder_if.slave  bus
);
    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(MEM_DEPTH);
    localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE_ADDR);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              full_q, full_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;

    logic              ready_c;
    logic              accept_c;
    logic [CNT_W-1:0]  count_inc_c;
    logic [31:0]       enc_c;

    // start takes priority over a beat presented in the same cycle
    assign ready_c     = (state_q == LOAD) && !full_q && !bus.start;
    assign accept_c    = bus.in_valid && ready_c;
    assign count_inc_c = count_q + CNT_W'(1);

    // Field packing, MSB first
    always_comb begin
        enc_c = '0;
        case (bus.fmt)
            2'b00:   enc_c = {bus.opcode, bus.rs, bus.rt, bus.rd, bus.shamt, bus.funct};
            2'b01:   enc_c = {bus.opcode, bus.rs, bus.rt, bus.immediate};
            2'b10:   enc_c = {bus.opcode, bus.address};
            default: enc_c = '0;
        endcase
    end

    // Next state and next register values
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        full_d  = full_q;
        done_d  = done_q;
        err_d   = err_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;

        if (bus.start) begin
            state_d = LOAD;
            count_d = '0;
            full_d  = 1'b0;
            done_d  = 1'b0;
            err_d   = 1'b0;
        end else if (accept_c) begin
            if (bus.fmt == 2'b11) begin
                err_d = 1'b1;
            end else begin
                we_d    = 1'b1;
                addr_d  = BASE_C + count_q[ADDR_W-1:0];
                wdata_d = enc_c;
                count_d = count_inc_c;
                full_d  = (count_inc_c == DEPTH_C);
            end
            if (bus.last) begin
                state_d = DONE;
                done_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= '0;
            full_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= BASE_C;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            full_q  <= full_d;
            done_q  <= done_d;
            err_q   <= err_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign bus.in_ready  = ready_c;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.count     = count_q;
    assign bus.full      = full_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_instruction_encoder.sv
// Bench for instruction_encoder: directed and randomized beats against a
// field-arithmetic reference model, on a large and a 4-deep instance.
module tb_instruction_encoder;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Shared stimulus; sel routes start/in_valid to one instance
    logic        sel;
    logic        start, in_valid, last;
    logic [1:0]  fmt;
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] immediate;
    logic [25:0] address;

    instruction_encoder_if #(.ADDR_W(10)) bus_a ();
    instruction_encoder_if #(.ADDR_W(3))  bus_b ();

    assign bus_a.start = start & ~sel;    assign bus_b.start = start & sel;
    assign bus_a.in_valid = in_valid & ~sel;  assign bus_b.in_valid = in_valid & sel;
    assign bus_a.last = last;             assign bus_b.last = last;
    assign bus_a.fmt = fmt;               assign bus_b.fmt = fmt;
    assign bus_a.opcode = opcode;         assign bus_b.opcode = opcode;
    assign bus_a.rs = rs;                 assign bus_b.rs = rs;
    assign bus_a.rt = rt;                 assign bus_b.rt = rt;
    assign bus_a.rd = rd;                 assign bus_b.rd = rd;
    assign bus_a.shamt = shamt;           assign bus_b.shamt = shamt;
    assign bus_a.funct = funct;           assign bus_b.funct = funct;
    assign bus_a.immediate = immediate;   assign bus_b.immediate = immediate;
    assign bus_a.address = address;       assign bus_b.address = address;

    instruction_encoder #(.MEM_DEPTH(1024), .ADDR_W(10), .BASE_ADDR(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a.slave));
    instruction_encoder #(.MEM_DEPTH(4), .ADDR_W(3), .BASE_ADDR(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b.slave));

    logic        o_ready, o_we, o_full, o_done, o_err;
    logic [9:0]  o_addr;
    logic [31:0] o_wdata;
    logic [10:0] o_count;
    assign o_ready = sel ? bus_b.in_ready : bus_a.in_ready;
    assign o_we    = sel ? bus_b.mem_we : bus_a.mem_we;
    assign o_addr  = sel ? 10'(bus_b.mem_addr) : bus_a.mem_addr;
    assign o_wdata = sel ? bus_b.mem_wdata : bus_a.mem_wdata;
    assign o_count = sel ? 11'(bus_b.count) : bus_a.count;
    assign o_full  = sel ? bus_b.full : bus_a.full;
    assign o_done  = sel ? bus_b.done : bus_a.done;
    assign o_err   = sel ? bus_b.err : bus_a.err;

    int vectors = 0;
    int miscompares = 0;
    int seen_writes = 0;

    // Reference model state
    int unsigned m_count, m_depth, m_base, m_writes;
    bit          m_done, m_err, m_load;

    always @(negedge clk) if (o_we === 1'b1) seen_writes++;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc(input logic [1:0] f, input logic [5:0] op,
                                        input logic [4:0] a_rs, input logic [4:0] a_rt,
                                        input logic [4:0] a_rd, input logic [4:0] a_sh,
                                        input logic [5:0] fn, input logic [15:0] im,
                                        input logic [25:0] ad);
        int unsigned w;
        case (f)
            2'd0: w = 32'(op) * 32'd67108864 + 32'(a_rs) * 32'd2097152 + 32'(a_rt) * 32'd65536
                    + 32'(a_rd) * 32'd2048 + 32'(a_sh) * 32'd64 + 32'(fn);
            2'd1: w = 32'(op) * 32'd67108864 + 32'(a_rs) * 32'd2097152 + 32'(a_rt) * 32'd65536
                    + 32'(im);
            2'd2: w = 32'(op) * 32'd67108864 + 32'(ad);
            default: w = 0;
        endcase
        return w;
    endfunction

    task automatic check_status();
        chk("count", 64'(o_count), 64'(m_count));
        chk("full", 64'(o_full), 64'(m_count == m_depth));
        chk("done", 64'(o_done), 64'(m_done));
        chk("err", 64'(o_err), 64'(m_err));
        chk("in_ready", 64'(o_ready), 64'(m_load && (m_count != m_depth)));
    endtask

    task automatic check_idle();
        @(negedge clk);
        chk("we_single_cycle", 64'(o_we), 64'(0));
        chk("write_count", 64'(seen_writes), 64'(m_writes));
    endtask

    // Called just after a negedge
    task automatic do_start();
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        m_count = 0; m_done = 0; m_err = 0; m_load = 1;
        #1 check_status();
    endtask

    task automatic beat(input logic [1:0] f, input logic [5:0] op, input logic [4:0] a_rs,
                        input logic [4:0] a_rt, input logic [4:0] a_rd, input logic [4:0] a_sh,
                        input logic [5:0] fn, input logic [15:0] im, input logic [25:0] ad,
                        input logic lst);
        int n;
        logic [31:0] exp_w;
        fmt = f; opcode = op; rs = a_rs; rt = a_rt; rd = a_rd; shamt = a_sh;
        funct = fn; immediate = im; address = ad; last = lst; in_valid = 1'b1;
        n = 0;
        while (o_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n == 20) begin
            chk("accept_timeout", 64'(o_ready), 64'(1));
            in_valid = 1'b0;
        end else begin
            exp_w = enc(f, op, a_rs, a_rt, a_rd, a_sh, fn, im, ad);
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
            if (f == 2'b11) begin
                m_err = 1;
                chk("we_illegal", 64'(o_we), 64'(0));
            end else begin
                chk("we", 64'(o_we), 64'(1));
                chk("addr", 64'(o_addr), 64'(m_base + m_count));
                chk("wdata", 64'(o_wdata), 64'(exp_w));
                m_count++;
                m_writes++;
            end
            if (lst) begin
                m_done = 1;
                m_load = 0;
            end
            check_status();
        end
    endtask

    task automatic rbeat(input logic [1:0] f, input logic lst);
        beat(f, 6'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
             6'($urandom), 16'($urandom), 26'($urandom), lst);
    endtask

    initial begin
        sel = 1'b0; start = 1'b0; in_valid = 1'b0; last = 1'b0; fmt = 2'b00;
        opcode = '0; rs = '0; rt = '0; rd = '0; shamt = '0; funct = '0;
        immediate = '0; address = '0;
        m_count = 0; m_depth = 1024; m_base = 0; m_writes = 0;
        m_done = 0; m_err = 0; m_load = 0;
        rst_n = 1'b0;

        // Reset values
        #12;
        chk("rst_we", 64'(o_we), 64'(0));
        chk("rst_addr", 64'(o_addr), 64'(0));
        chk("rst_wdata", 64'(o_wdata), 64'(0));
        check_status();
        @(negedge clk);
        rst_n = 1'b1;

        // IDLE ignores beats
        in_valid = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_ready", 64'(o_ready), 64'(0));
        chk("idle_count", 64'(o_count), 64'(0));
        in_valid = 1'b0;

        // R-type
        do_start();
        beat(2'b00, 6'd0, 5'd31, 5'd0, 5'd28, 5'd3, 6'h2B, 16'h0, 26'h0, 1'b0);
        chk("rtype_word", 64'(o_wdata), 64'h03E0E0EB);
        chk("rtype_addr", 64'(o_addr), 64'(0));

        // Start wins over a beat in LOAD; the in-flight write still completes
        start = 1'b1; in_valid = 1'b1;
        #1;
        chk("start_ready_load", 64'(o_ready), 64'(0));
        chk("inflight_we", 64'(o_we), 64'(1));
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; in_valid = 1'b0;
        m_count = 0; m_done = 0; m_err = 0; m_load = 1;
        #1 check_status();
        chk("start_no_write", 64'(o_we), 64'(0));

        // I-type then J-type back-to-back
        beat(2'b01, 6'h23, 5'd31, 5'd0, 5'd0, 5'd0, 6'd0, 16'h55A6, 26'h0, 1'b0);
        chk("itype_word", 64'(o_wdata), 64'h8FE055A6);
        beat(2'b10, 6'h02, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0, 26'h2970CE9, 1'b1);
        chk("jtype_word", 64'(o_wdata), 64'h0A970CE9);
        chk("jtype_addr", 64'(o_addr), 64'(1));
        check_idle();

        // Start with a beat in DONE
        start = 1'b1; in_valid = 1'b1;
        #1 chk("start_ready_done", 64'(o_ready), 64'(0));
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; in_valid = 1'b0;
        m_count = 0; m_done = 0; m_err = 0; m_load = 1;
        #1 check_status();
        chk("restart_no_write", 64'(o_we), 64'(0));

        // Illegal format then R-type
        rbeat(2'b11, 1'b0);
        rbeat(2'b00, 1'b0);
        chk("after_illegal_addr", 64'(o_addr), 64'(0));
        check_idle();

        // Randomized program with idle gaps
        do_start();
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(3) == 0) @(negedge clk);
            rbeat(2'($urandom_range(3)), 1'(i == 39));
        end
        check_idle();

        // Reset while a write is in flight
        do_start();
        rbeat(2'b01, 1'b0);
        #2 rst_n = 1'b0;
        m_count = 0; m_done = 0; m_err = 0; m_load = 0;
        #1;
        chk("rst_mid_we", 64'(o_we), 64'(0));
        chk("rst_mid_addr", 64'(o_addr), 64'(0));
        chk("rst_mid_wdata", 64'(o_wdata), 64'(0));
        check_status();
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst_idle_ready", 64'(o_ready), 64'(0));
        in_valid = 1'b0;
        check_idle();

        // Full on the 4-deep instance at base 4
        sel = 1'b1; m_depth = 4; m_base = 4;
        @(negedge clk);
        do_start();
        for (int i = 0; i < 4; i++) rbeat(2'($urandom_range(2)), 1'b0);
        chk("full_last_addr", 64'(o_addr), 64'(7));
        fmt = 2'b00; last = 1'b1; in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("full_held_ready", 64'(o_ready), 64'(0));
        end
        chk("full_count", 64'(o_count), 64'(4));
        chk("full_done", 64'(o_done), 64'(0));
        in_valid = 1'b0; last = 1'b0;
        check_idle();
        do_start();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
